// File: rtl/mod_interp_pkg.sv
// Shared definitions for the linear up-sampling interpolator.
// K must track the window exponent of the companion block-average filter.
package mod_interp_pkg;

   localparam int K_DEF  = 10;
   localparam int DW_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_RAMP = 2'd2
   } state_t;

endpackage

// File: rtl/mod_interp_acc.sv
// Step/accumulator/phase datapath of the interpolator: the output is acc scaled by 2^K,
// and after 2^K additions of step the accumulator lands exactly on the new target.
module mod_interp_acc
   import mod_interp_pkg::*;
#(
   parameter int K  = K_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_jump,
   input  logic          load_ramp,
   input  logic          run,
   input  logic [DW-1:0] sample,
   output logic [DW-1:0] value,
   output logic          done
);

   localparam int          AW        = DW + K + 1;
   localparam logic [K:0]  PHASE_END = {1'b1, {K{1'b0}}};
   localparam logic [K:0]  PHASE_ONE = (K+1)'(1);

   logic signed [AW-1:0] acc_reg;
   logic signed [DW:0]   step_reg;
   logic        [K:0]    phase_reg;
   logic        [DW-1:0] target_reg;

   logic signed [DW:0]   step_new;
   logic signed [AW-1:0] step_ext;
   logic signed [AW-1:0] step_new_ext;
   logic signed [AW-1:0] target_scaled;
   logic signed [AW-1:0] sample_scaled;

   // Both operands are zero-extended, so the 17-bit difference is an exact signed step.
   assign step_new      = $signed({1'b0, sample}) - $signed({1'b0, target_reg});
   assign step_ext      = {{K{step_reg[DW]}}, step_reg};
   assign step_new_ext  = {{K{step_new[DW]}}, step_new};
   assign target_scaled = {1'b0, target_reg, {K{1'b0}}};
   assign sample_scaled = {1'b0, sample, {K{1'b0}}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg    <= '0;
         step_reg   <= '0;
         phase_reg  <= '0;
         target_reg <= '0;
      end else if (load_jump) begin
         acc_reg    <= sample_scaled;
         step_reg   <= '0;
         phase_reg  <= '0;
         target_reg <= sample;
      end else if (load_ramp) begin
         // A new ramp always restarts from the last target, even mid-ramp.
         acc_reg    <= target_scaled + step_new_ext;
         step_reg   <= step_new;
         phase_reg  <= PHASE_ONE;
         target_reg <= sample;
      end else if (run) begin
         acc_reg   <= acc_reg + step_ext;
         phase_reg <= phase_reg + PHASE_ONE;
      end
   end

   assign value = acc_reg[DW+K-1:K];
   assign done  = (phase_reg == PHASE_END);

endmodule

// File: rtl/mod_interp.sv
// Linear up-sampling interpolator: ramps the per-clock output from the previous target
// to each new low-rate sample over exactly 2^K clocks.
module mod_interp
   import mod_interp_pkg::*;
#(
   parameter int K  = K_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          pClk,
   input  logic          pRst,
   input  logic [DW-1:0] pSampleIn,
   input  logic          pSampleVld,
   output logic [DW-1:0] pInterpOut,
   output logic          pInterpVld,
   output logic          pRampActive,
   output logic          pOverrun,
   output logic          pUnderrun
);

   state_t state_reg, state_next;
   logic   interp_vld_reg, interp_vld_next;
   logic   overrun_reg, overrun_next;
   logic   underrun_reg, underrun_next;
   logic   load_jump, load_ramp, run, done;

   mod_interp_acc #(
      .K  (K),
      .DW (DW)
   ) u_acc (
      .clk       (pClk),
      .rst_n     (pRst),
      .load_jump (load_jump),
      .load_ramp (load_ramp),
      .run       (run),
      .sample    (pSampleIn),
      .value     (pInterpOut),
      .done      (done)
   );

   always_ff @(posedge pClk or negedge pRst) begin
      if (!pRst) begin
         state_reg      <= ST_IDLE;
         interp_vld_reg <= 1'b0;
         overrun_reg    <= 1'b0;
         underrun_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         interp_vld_reg <= interp_vld_next;
         overrun_reg    <= overrun_next;
         underrun_reg   <= underrun_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      interp_vld_next = interp_vld_reg;
      overrun_next    = 1'b0;
      underrun_next   = 1'b0;
      load_jump       = 1'b0;
      load_ramp       = 1'b0;
      run             = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (pSampleVld) begin
               load_jump       = 1'b1;
               interp_vld_next = 1'b1;
               state_next      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (pSampleVld) begin
               load_ramp  = 1'b1;
               state_next = ST_RAMP;
            end
         end
         ST_RAMP: begin
            // A sample landing exactly on the completing edge chains ramps without a flag.
            if (pSampleVld) begin
               load_ramp    = 1'b1;
               overrun_next = !done;
            end else if (done) begin
               underrun_next = 1'b1;
               state_next    = ST_HOLD;
            end else begin
               run = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign pInterpVld  = interp_vld_reg;
   assign pRampActive = (state_reg == ST_RAMP);
   assign pOverrun    = overrun_reg;
   assign pUnderrun   = underrun_reg;

endmodule

// File: tb/tb_mod_interp.sv
// Bench for mod_interp: directed scenarios plus random traffic, every cycle checked
// against a reference that evaluates old + floor(step*k/2^K) directly.
module tb_mod_interp;

   localparam int K  = 10;
   localparam int DW = 16;
   localparam int N  = 1 << K;

   logic          pClk = 1'b0;
   logic          pRst = 1'b0;
   logic [DW-1:0] pSampleIn = '0;
   logic          pSampleVld = 1'b0;
   logic [DW-1:0] pInterpOut;
   logic          pInterpVld;
   logic          pRampActive;
   logic          pOverrun;
   logic          pUnderrun;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   // Reference state: mode 0=idle 1=hold 2=ramp; ramp goes from m_from to m_to, k edges in.
   int m_mode, m_from, m_to, m_k, m_vld, m_ov, m_un;

   mod_interp #(
      .K  (K),
      .DW (DW)
   ) dut (
      .pClk        (pClk),
      .pRst        (pRst),
      .pSampleIn   (pSampleIn),
      .pSampleVld  (pSampleVld),
      .pInterpOut  (pInterpOut),
      .pInterpVld  (pInterpVld),
      .pRampActive (pRampActive),
      .pOverrun    (pOverrun),
      .pUnderrun   (pUnderrun)
   );

   always #5 pClk = ~pClk;

   function automatic int floor_div(int a, int b);
      int q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int model_out();
      if (m_mode == 0) return 0;
      if (m_mode == 1) return m_to;
      return m_from + floor_div((m_to - m_from) * m_k, N);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_from = 0; m_to = 0; m_k = 0; m_vld = 0; m_ov = 0; m_un = 0;
   endtask

   task automatic model_edge(input bit v, input int s);
      m_ov = 0;
      m_un = 0;
      case (m_mode)
         0: if (v) begin
               m_from = s; m_to = s; m_k = N; m_mode = 1; m_vld = 1;
            end
         1: if (v) begin
               m_from = m_to; m_to = s; m_k = 1; m_mode = 2;
            end
         default: begin
            if (v) begin
               if (m_k < N) m_ov = 1;
               m_from = m_to; m_to = s; m_k = 1;
            end else if (m_k == N) begin
               m_mode = 1; m_un = 1;
            end else begin
               m_k = m_k + 1;
            end
         end
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      check("out",      32'(pInterpOut),  32'(model_out()));
      check("vld",      32'(pInterpVld),  32'(m_vld));
      check("ramp",     32'(pRampActive), 32'(m_mode == 2));
      check("overrun",  32'(pOverrun),    32'(m_ov));
      check("underrun", 32'(pUnderrun),   32'(m_un));
   endtask

   task automatic step(input bit v, input int s);
      @(negedge pClk);
      pSampleVld = v;
      pSampleIn  = s[DW-1:0];
      @(posedge pClk);
      model_edge(v, s);
      #1;
      check_all();
      if (v) $display("sample %0d accepted at %0t: out=%0d overrun=%0d", s, $time, pInterpOut, pOverrun);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 65535));
   endtask

   initial begin
      int prev;
      int rs;
      bit rv;

      // Reset state
      model_reset();
      repeat (3) @(posedge pClk);
      #1;
      check_all();
      check("rst_out", 32'(pInterpOut), 32'd0);
      @(negedge pClk);
      pRst = 1'b1;

      // First sample is a jump
      step(1'b1, 1000);
      check("t1_out", 32'(pInterpOut), 32'd1000);
      check("t1_vld", 32'(pInterpVld), 32'd1);
      check("t1_hold", 32'(pRampActive), 32'd0);
      idle(3);

      // Upward ramp 1000 -> 2024
      step(1'b1, 2024);
      check("t2_e1", 32'(pInterpOut), 32'd1001);
      idle(511);
      check("t2_e512", 32'(pInterpOut), 32'd1512);
      idle(512);
      check("t2_e1024", 32'(pInterpOut), 32'd2024);
      idle(1);
      check("t2_under", 32'(pUnderrun), 32'd1);
      idle(1);
      check("t2_under_off", 32'(pUnderrun), 32'd0);
      check("t2_holdval", 32'(pInterpOut), 32'd2024);

      // Downward ramp 2024 -> 0, monotone
      step(1'b1, 0);
      for (int j = 2; j <= N; j++) begin
         prev = int'(pInterpOut);
         step(1'b0, 0);
         check("t3_mono", 32'(int'(pInterpOut) <= prev), 32'd1);
         if (j == 512) check("t3_e512", 32'(pInterpOut), 32'd1012);
      end
      check("t3_end", 32'(pInterpOut), 32'd0);
      idle(1);

      // Overrun snap at phase 300
      step(1'b1, 4096);
      idle(299);
      step(1'b1, 100);
      check("t4_snap", 32'(pInterpOut), 32'd4092);
      check("t4_over", 32'(pOverrun), 32'd1);
      idle(1023);
      check("t4_end", 32'(pInterpOut), 32'd100);

      // Back-to-back full-scale ramps on the completing edge
      step(1'b1, 0);
      idle(1023);
      check("t5_zero", 32'(pInterpOut), 32'd0);
      step(1'b1, 65535);
      idle(1023);
      check("t5_full", 32'(pInterpOut), 32'd65535);
      step(1'b1, 0);
      check("t5_no_over", 32'(pOverrun), 32'd0);
      idle(1023);
      check("t5_back", 32'(pInterpOut), 32'd0);

      // Asynchronous reset mid-ramp
      step(1'b1, 30000);
      idle(100);
      @(negedge pClk);
      pSampleVld = 1'b0;
      #2;
      pRst = 1'b0;
      model_reset();
      #1;
      check_all();
      check("t6_async_ramp", 32'(pRampActive), 32'd0);
      @(posedge pClk);
      #1;
      check_all();
      @(negedge pClk);
      pRst = 1'b1;
      step(1'b1, 500);
      check("t6_jump", 32'(pInterpOut), 32'd500);
      check("t6_noramp", 32'(pRampActive), 32'd0);

      // Random traffic, biased to sometimes hit the completing edge exactly
      for (int i = 0; i < 8000; i++) begin
         rv = ($urandom_range(0, 599) == 0);
         if (m_mode == 2 && m_k == N && $urandom_range(0, 1) == 0) rv = 1'b1;
         rs = int'($urandom_range(0, 65535));
         step(rv, rs);
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
